// File: rtl/alu_1bit_pkg.sv
// Shared encodings for the 1-bit ALU slice: operation groups and sub-op codes.
package alu_1bit_pkg;

    localparam int unsigned SEL_W = 4;
    localparam int unsigned GRP_W = 2;
    localparam int unsigned SUB_W = 2;

    // Group codes (sel[3:2])
    localparam logic [GRP_W-1:0] GRP_ARITH = 2'b00;
    localparam logic [GRP_W-1:0] GRP_LOGIC = 2'b01;
    localparam logic [GRP_W-1:0] GRP_SHR   = 2'b10;
    localparam logic [GRP_W-1:0] GRP_SHL   = 2'b11;

    // Arithmetic B-variant codes (sel[1:0])
    localparam logic [SUB_W-1:0] B_ZERO = 2'b00;
    localparam logic [SUB_W-1:0] B_PASS = 2'b01;
    localparam logic [SUB_W-1:0] B_INV  = 2'b10;
    localparam logic [SUB_W-1:0] B_ONE  = 2'b11;

    // Logic op codes (sel[1:0])
    localparam logic [SUB_W-1:0] OP_AND  = 2'b00;
    localparam logic [SUB_W-1:0] OP_OR   = 2'b01;
    localparam logic [SUB_W-1:0] OP_XOR  = 2'b10;
    localparam logic [SUB_W-1:0] OP_NOTA = 2'b11;

endpackage

// File: rtl/alu_1bit_core.sv
// Combinational datapath of the 1-bit ALU slice: adder, logic unit, shift taps, result mux.
module alu_1bit_core
    import alu_1bit_pkg::*;
(
    input  logic             Ai,
    input  logic             Bi,
    input  logic             A_prev,
    input  logic             A_next,
    input  logic             Cini,
    input  logic [SEL_W-1:0] sel,
    output logic             f_c,
    output logic             cout_c
);

    logic [GRP_W-1:0] grp;
    logic [SUB_W-1:0] sub;
    logic             b_var;
    logic [1:0]       sum;
    logic             logic_res;

    assign grp = sel[SEL_W-1:SUB_W];
    assign sub = sel[SUB_W-1:0];

    // B operand variant feeding the adder
    always_comb begin
        b_var = 1'b0;
        case (sub)
            B_ZERO:  b_var = 1'b0;
            B_PASS:  b_var = Bi;
            B_INV:   b_var = ~Bi;
            B_ONE:   b_var = 1'b1;
            default: b_var = 1'b0;
        endcase
    end

    assign sum = 2'(Ai) + 2'(b_var) + 2'(Cini);

    always_comb begin
        logic_res = 1'b0;
        case (sub)
            OP_AND:  logic_res = Ai & Bi;
            OP_OR:   logic_res = Ai | Bi;
            OP_XOR:  logic_res = Ai ^ Bi;
            OP_NOTA: logic_res = ~Ai;
            default: logic_res = 1'b0;
        endcase
    end

    // Carry is always the adder carry, whatever group drives the result
    always_comb begin
        f_c    = 1'b0;
        cout_c = sum[1];
        case (grp)
            GRP_ARITH: f_c = sum[0];
            GRP_LOGIC: f_c = logic_res;
            GRP_SHR:   f_c = A_prev;
            GRP_SHL:   f_c = A_next;
            default:   f_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_1bit.sv
// 1-bit ALU slice top. ALU_1BIT_OUT_REG_EN adds a 1-cycle output register with async reset;
// without it the outputs are combinational and clk/rst are ignored.
module alu_1bit
    import alu_1bit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             Ai,
    input  logic             Bi,
    input  logic             A_prev,
    input  logic             A_next,
    input  logic             Cini,
    input  logic [SEL_W-1:0] sel,
    output logic             Fi,
    output logic             Couti
);

    logic f_c;
    logic cout_c;

    alu_1bit_core u_core (
        .Ai     (Ai),
        .Bi     (Bi),
        .A_prev (A_prev),
        .A_next (A_next),
        .Cini   (Cini),
        .sel    (sel),
        .f_c    (f_c),
        .cout_c (cout_c)
    );

`ifdef ALU_1BIT_OUT_REG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Fi    <= 1'b0;
            Couti <= 1'b0;
        end else begin
            Fi    <= f_c;
            Couti <= cout_c;
        end
    end
`else
    // clk/rst are intentionally dead in the combinational build
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};

    assign Fi    = f_c;
    assign Couti = cout_c;
`endif

endmodule

// File: tb/tb_alu_1bit.sv
// Self-checking bench for alu_1bit: exhaustive sweep against a reference model plus directed
// vectors; define ALU_1BIT_OUT_REG_EN to exercise the registered build.
`timescale 1ns/1ps
module tb_alu_1bit;

    logic       clk;
    logic       rst;
    logic       Ai;
    logic       Bi;
    logic       A_prev;
    logic       A_next;
    logic       Cini;
    logic [3:0] sel;
    logic       Fi;
    logic       Couti;

    int checks;
    int errors;

    alu_1bit dut (
        .clk    (clk),
        .rst    (rst),
        .Ai     (Ai),
        .Bi     (Bi),
        .A_prev (A_prev),
        .A_next (A_next),
        .Cini   (Cini),
        .sel    (sel),
        .Fi     (Fi),
        .Couti  (Couti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Reference model written from the operation tables
    function automatic logic [1:0] ref_model(input logic [3:0] s, input logic a, input logic b,
                                             input logic ap, input logic an, input logic ci);
        logic       bv;
        logic       e;
        logic       f;
        logic [1:0] sm;
        case (s[1:0])
            2'b00:   bv = 1'b0;
            2'b01:   bv = b;
            2'b10:   bv = ~b;
            default: bv = 1'b1;
        endcase
        sm = {1'b0, a} + {1'b0, bv} + {1'b0, ci};
        case (s[1:0])
            2'b00:   e = a & b;
            2'b01:   e = a | b;
            2'b10:   e = a ^ b;
            default: e = ~a;
        endcase
        case (s[3:2])
            2'b00:   f = sm[0];
            2'b01:   f = e;
            2'b10:   f = ap;
            default: f = an;
        endcase
        return {f, sm[1]};
    endfunction

    task automatic drive(input logic [3:0] s, input logic a, input logic b,
                         input logic ap, input logic an, input logic ci);
        sel = s; Ai = a; Bi = b; A_prev = ap; A_next = an; Cini = ci;
    endtask

    // Let the applied inputs reach the outputs
    task automatic settle();
`ifdef ALU_1BIT_OUT_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    initial begin
        logic [1:0] exp;
        logic [8:0] v;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        #2;
`ifdef ALU_1BIT_OUT_REG_EN
        check("reset_fi", Fi, 1'b0);
        check("reset_couti", Couti, 1'b0);
`else
        check("rst_ignored_fi", Fi, 1'b0);
        check("rst_ignored_couti", Couti, 1'b1);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive sweep of all 512 input combinations
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            drive(v[8:5], v[4], v[3], v[2], v[1], v[0]);
            settle();
            exp = ref_model(v[8:5], v[4], v[3], v[2], v[1], v[0]);
            check($sformatf("sweep_fi_%0d", i), Fi, exp[1]);
            check($sformatf("sweep_couti_%0d", i), Couti, exp[0]);
        end

        // Directed vectors with hand-computed results
        drive(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);  // 1+1+1 = 11
        settle();
        check("add_fi", Fi, 1'b1);
        check("add_couti", Couti, 1'b1);

        drive(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);  // increment of 1
        settle();
        check("inc1_fi", Fi, 1'b0);
        check("inc1_couti", Couti, 1'b1);

        drive(4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);  // increment of 0
        settle();
        check("inc0_fi", Fi, 1'b1);
        check("inc0_couti", Couti, 1'b0);

        drive(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);  // 1 + ~1 + 1 = 10
        settle();
        check("sub_fi", Fi, 1'b0);
        check("sub_couti", Couti, 1'b1);

        drive(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);  // ~A, carry of 0+1+1
        settle();
        check("nota_fi", Fi, 1'b1);
        check("nota_couti", Couti, 1'b1);

        drive(4'b1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        check("shr_fi", Fi, 1'b1);
        check("shr_couti", Couti, 1'b0);

        drive(4'b1100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        check("shl_fi", Fi, 1'b0);

        drive(4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // xor
        settle();
        check("xor_fi", Fi, 1'b0);
        check("xor_couti", Couti, 1'b0);

`ifdef ALU_1BIT_OUT_REG_EN
        // Fi=1 (shift right of 1), Couti=1 (1+0+1)
        drive(4'b1000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        settle();
        check("pre_rst_fi", Fi, 1'b1);
        check("pre_rst_couti", Couti, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_fi", Fi, 1'b0);
        check("async_rst_couti", Couti, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rel_hold_fi", Fi, 1'b0);
        @(posedge clk);
        #1;
        check("rst_rel_load_fi", Fi, 1'b1);
        check("rst_rel_load_couti", Couti, 1'b1);

        // Inputs changed between edges must not show until the next edge
        drive(4'b1100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        check("hold_fi", Fi, 1'b1);
        check("hold_couti", Couti, 1'b1);
        @(posedge clk);
        #1;
        check("update_fi", Fi, 1'b0);
        check("update_couti", Couti, 1'b0);
`else
        // rst has no effect on the combinational build
        drive(4'b1000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check("comb_rst_fi", Fi, 1'b1);
        check("comb_rst_couti", Couti, 1'b1);
        rst = 1'b0;
        drive(4'b1100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check("comb_zero_lat_fi", Fi, 1'b0);
        check("comb_zero_lat_couti", Couti, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
